seq_match_ctrl: RTL and testbench



---
 rtl/seq_match_pkg.sv | 24 ++
 rtl/seq_shift_matcher.sv | 63 ++++++
 rtl/seq_match_ctrl.sv | 149 ++++++++++++++
 tb/tb_seq_match_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_match_pkg.sv
// seq_match_pkg: shared types and helpers for the programmable sequence matcher.
//   state_t       - controller states (IDLE, RUN, DONE)
//   *_DEF         - default parameter widths
//   cfg_legal()   - start-time legality check for pattern length and match target
package seq_match_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int TO_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A run needs a pattern of 1..max_len bits and a non-zero match target.
  function automatic logic cfg_legal(input int unsigned len,
                                     input int unsigned max_len,
                                     input logic        target_nz);
    return (len != 0) && (len <= max_len) && target_nz;
  endfunction

endpackage

// File: rtl/seq_shift_matcher.sv
// seq_shift_matcher: serial history register, fill counter and masked compare.
//   clk, reset : clock, synchronous active-high reset
//   clear      : empties history and fill (start of a run)
//   shift      : accept one qualified bit this cycle
//   data       : serial bit
//   pattern    : pattern, bit len-1 is the first-received bit
//   len        : active pattern length (1..PAT_W)
//   overlap    : 1 = keep fill after a match, 0 = restart the fill
//   hit        : combinational; this shift completes a match
module seq_shift_matcher
  import seq_match_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       shift,
  input  logic                       data,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [$clog2(PAT_W+1)-1:0] len,
  input  logic                       overlap,
  output logic                       hit
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] history;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_next;

  // The match is judged on the post-shift view, so the bit arriving this
  // cycle takes part in the compare and hit can be registered next edge.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    hist_next = (history << 1) | PAT_W'(data);
    fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    mask      = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    // Bits at or above len are masked off; fill gates stale history after
    // a non-overlapping restart.
    hit = shift && (fill_next >= len) &&
          ((hist_next & mask) == (pattern & mask));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift) begin
      history <= hist_next;
      fill    <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: arms and sequences a programmable serial pattern detector.
//   clk, reset   : clock, synchronous active-high reset
//   start        : pulse, begins a run when idle
//   abort        : level, ends a run without done
//   cfg_*        : pattern, length, match target, timeout (0 = none), overlap
//   data         : serial bit, qualified by data_valid
//   busy         : high while running
//   match_pulse  : one-cycle pulse per detected match
//   match_count  : matches in the current / last run
//   done         : one-cycle pulse at run end
//   timed_out    : with done, 1 = run ended by timeout
//   cfg_err      : one-cycle pulse on a rejected start
module seq_match_ctrl
  import seq_match_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TO_W  = TO_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic [CNT_W-1:0]           cfg_target,
  input  logic [TO_W-1:0]            cfg_timeout,
  input  logic                       cfg_overlap,
  input  logic                       data,
  input  logic                       data_valid,
  output logic                       busy,
  output logic                       match_pulse,
  output logic [CNT_W-1:0]           match_count,
  output logic                       done,
  output logic                       timed_out,
  output logic                       cfg_err
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  state_t           state;
  state_t           state_next;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] target_q;
  logic [TO_W-1:0]  timeout_q;
  logic             overlap_q;
  logic [TO_W-1:0]  timer;
  logic             to_end;

  logic cfg_ok;
  logic start_ok;
  logic start_bad;
  logic shift;
  logic hit;
  logic final_hit;
  logic timeout_hit;
  logic end_by_timeout;

  assign cfg_ok    = cfg_legal(32'(cfg_len), PAT_W, cfg_target != '0);
  assign start_ok  = (state == IDLE) && start && cfg_ok;
  assign start_bad = (state == IDLE) && start && !cfg_ok;
  assign shift     = (state == RUN) && data_valid;

  seq_shift_matcher #(
    .PAT_W (PAT_W)
  ) u_matcher (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .shift   (shift),
    .data    (data),
    .pattern (pat_q),
    .len     (len_q),
    .overlap (overlap_q),
    .hit     (hit)
  );

  assign final_hit   = hit && ((match_count + 1'b1) == target_q);
  // timer counts completed RUN cycles, so timeout-1 marks the last one.
  assign timeout_hit = (timeout_q != '0) && (timer == timeout_q - 1'b1);

  // Priority in RUN: abort, then final match, then timeout.
  always_comb begin
    state_next     = state;
    end_by_timeout = 1'b0;
    unique case (state)
      IDLE: if (start_ok) state_next = RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (final_hit) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next     = DONE;
          end_by_timeout = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the configuration registers are cleared too even though they
      // are only consumed in RUN, so nothing downstream ever sees X.
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      target_q    <= '0;
      timeout_q   <= '0;
      overlap_q   <= 1'b0;
      timer       <= '0;
      to_end      <= 1'b0;
      busy        <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_next;
      busy        <= (state_next == RUN);
      match_pulse <= hit;
      // done is registered out of the DONE cycle itself.
      done        <= (state == DONE);
      timed_out   <= (state == DONE) && to_end;
      cfg_err     <= start_bad;

      if (start_ok) begin
        pat_q       <= cfg_pattern;
        len_q       <= cfg_len;
        target_q    <= cfg_target;
        timeout_q   <= cfg_timeout;
        overlap_q   <= cfg_overlap;
        timer       <= '0;
        to_end      <= 1'b0;
        match_count <= '0;
      end else if (state == RUN) begin
        timer <= timer + 1'b1;
        // A match on an abort cycle still counts; only done is suppressed.
        if (hit) match_count <= match_count + 1'b1;
        if (state_next == DONE) to_end <= end_by_timeout;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: directed bench for seq_match_ctrl with a queue-based
// reference model compared against the DUT outputs on every cycle, plus
// hand-computed literal expectations at key points of each scenario.
module tb_seq_match_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int TO_W  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic [TO_W-1:0]  cfg_timeout;
  logic             cfg_overlap;
  logic             data;
  logic             data_valid;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             timed_out;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;

  seq_match_ctrl #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .TO_W  (TO_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .cfg_overlap (cfg_overlap),
    .data        (data),
    .data_valid  (data_valid),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .done        (done),
    .timed_out   (timed_out),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the bits seen since the run started (or since the last
  // non-overlapping match) and decides matches by comparing the newest
  // len bits against the pattern, newest bit against pattern bit 0.
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t    ph = M_IDLE;
  bit         q[$];
  logic [7:0] m_pat = '0;
  int         m_len = 0, m_target = 0, m_timeout = 0, m_cycles = 0, m_count = 0;
  bit         m_ovl = 0, m_to = 0;
  logic       e_busy = 0, e_pulse = 0, e_done = 0, e_to = 0, e_err = 0;
  int         e_count = 0;

  always @(posedge clk) begin : model
    bit matched;
    e_pulse = 0;
    e_done  = 0;
    e_to    = 0;
    e_err   = 0;
    if (reset) begin
      ph      = M_IDLE;
      m_count = 0;
      q.delete();
    end else begin
      case (ph)
        M_IDLE: begin
          if (start) begin
            if (int'(cfg_len) >= 1 && int'(cfg_len) <= PAT_W && int'(cfg_target) >= 1) begin
              m_pat     = cfg_pattern;
              m_len     = int'(cfg_len);
              m_target  = int'(cfg_target);
              m_timeout = int'(cfg_timeout);
              m_ovl     = cfg_overlap;
              m_cycles  = 0;
              m_count   = 0;
              q.delete();
              ph = M_RUN;
            end else begin
              e_err = 1;
            end
          end
        end
        M_RUN: begin
          matched = 0;
          m_cycles++;
          if (data_valid) begin
            q.push_back(data);
            if (q.size() > PAT_W) void'(q.pop_front());
            if (q.size() >= m_len) begin
              matched = 1;
              for (int k = 0; k < m_len; k++)
                if (q[q.size() - 1 - k] != m_pat[k]) matched = 0;
            end
          end
          if (matched) begin
            m_count++;
            e_pulse = 1;
            if (!m_ovl) q.delete();
          end
          if (abort) ph = M_IDLE;
          else if (matched && m_count == m_target) begin
            ph   = M_DONE;
            m_to = 0;
          end else if (m_timeout != 0 && m_cycles == m_timeout) begin
            ph   = M_DONE;
            m_to = 1;
          end
        end
        M_DONE: begin
          e_done = 1;
          e_to   = m_to;
          ph     = M_IDLE;
        end
        default: ph = M_IDLE;
      endcase
    end
    e_busy  = (ph == M_RUN);
    e_count = m_count;
  end

  // Compare on the falling edge, well away from the sampling edge.
  always @(negedge clk) begin
    check("busy",        32'(busy),        32'(e_busy));
    check("match_pulse", 32'(match_pulse), 32'(e_pulse));
    check("match_count", 32'(match_count), 32'(e_count));
    check("done",        32'(done),        32'(e_done));
    check("timed_out",   32'(timed_out),   32'(e_to));
    check("cfg_err",     32'(cfg_err),     32'(e_err));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt,
                     input logic [15:0] to, input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_target  = tgt;
    cfg_timeout = to;
    cfg_overlap = ovl;
    start       = 1'b1;
    cyc();
    start       = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    data       = b;
    data_valid = 1'b1;
    cyc();
    data_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; data = 1'b0; data_valid = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_target = '0; cfg_timeout = '0; cfg_overlap = 1'b0;
    cyc();
    cyc();
    check("reset busy",  32'(busy), 32'd0);
    check("reset count", 32'(match_count), 32'd0);
    check("reset done",  32'(done), 32'd0);
    reset = 1'b0;
    cyc();

    // 1: 010, overlap, target 2
    arm(8'b010, 4'd3, 8'd2, 16'd0, 1'b1);
    check("t1 busy after start", 32'(busy), 32'd1);
    bit_in(0); bit_in(1);
    check("t1 no pulse bit2", 32'(match_pulse), 32'd0);
    bit_in(0);
    check("t1 pulse bit3", 32'(match_pulse), 32'd1);
    bit_in(1); bit_in(0);
    check("t1 pulse bit5", 32'(match_pulse), 32'd1);
    check("t1 count", 32'(match_count), 32'd2);
    check("t1 busy low", 32'(busy), 32'd0);
    cyc();
    check("t1 done", 32'(done), 32'd1);
    check("t1 timed_out", 32'(timed_out), 32'd0);
    cyc();

    // 2: same stream, no overlap
    arm(8'b010, 4'd3, 8'd2, 16'd0, 1'b0);
    bit_in(0); bit_in(1); bit_in(0);
    check("t2 count bit3", 32'(match_count), 32'd1);
    bit_in(1); bit_in(0);
    check("t2 no pulse bit5", 32'(match_pulse), 32'd0);
    check("t2 count bit5", 32'(match_count), 32'd1);
    check("t2 still busy", 32'(busy), 32'd1);
    bit_in(1); bit_in(0);
    check("t2 pulse bit7", 32'(match_pulse), 32'd1);
    check("t2 count bit7", 32'(match_count), 32'd2);
    cyc();
    check("t2 done", 32'(done), 32'd1);
    cyc();

    // 4: illegal starts
    arm(8'b010, 4'd0, 8'd2, 16'd0, 1'b1);
    check("t4 len0 err", 32'(cfg_err), 32'd1);
    check("t4 len0 busy", 32'(busy), 32'd0);
    check("t4 len0 count", 32'(match_count), 32'd2);
    cyc();
    check("t4 err cleared", 32'(cfg_err), 32'd0);
    arm(8'b010, 4'd3, 8'd0, 16'd0, 1'b1);
    check("t4 tgt0 err", 32'(cfg_err), 32'd1);
    arm(8'b010, 4'd9, 8'd1, 16'd0, 1'b1);
    check("t4 len9 err", 32'(cfg_err), 32'd1);
    check("t4 len9 busy", 32'(busy), 32'd0);
    cyc();

    // 3: timeout of 10 with no matches
    arm(8'b010, 4'd3, 8'd5, 16'd10, 1'b1);
    check("t3 count cleared", 32'(match_count), 32'd0);
    data = 1'b1; data_valid = 1'b1;
    repeat (9) cyc();
    check("t3 busy cycle 10", 32'(busy), 32'd1);
    cyc();
    check("t3 busy low", 32'(busy), 32'd0);
    cyc();
    check("t3 done", 32'(done), 32'd1);
    check("t3 timed_out", 32'(timed_out), 32'd1);
    check("t3 count", 32'(match_count), 32'd0);
    data_valid = 1'b0;
    cyc();

    // 5a: abort after one match
    arm(8'b010, 4'd3, 8'd3, 16'd0, 1'b1);
    bit_in(0); bit_in(1); bit_in(0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t5 abort busy", 32'(busy), 32'd0);
    check("t5 abort count", 32'(match_count), 32'd1);
    cyc();
    check("t5 abort no done", 32'(done), 32'd0);
    cyc();
    check("t5 abort no done 2", 32'(done), 32'd0);

    // 5b: reset mid-run
    arm(8'b010, 4'd3, 8'd3, 16'd0, 1'b1);
    bit_in(0); bit_in(1); bit_in(0);
    check("t5 pre-reset count", 32'(match_count), 32'd1);
    reset = 1'b1; data = 1'b1; data_valid = 1'b1;
    cyc();
    reset = 1'b0; data_valid = 1'b0;
    check("t5 reset busy", 32'(busy), 32'd0);
    check("t5 reset count", 32'(match_count), 32'd0);
    check("t5 reset pulse", 32'(match_pulse), 32'd0);
    cyc();
    check("t5 reset no done", 32'(done), 32'd0);

    // 6: final match on the timeout cycle; starts in RUN and DONE ignored
    arm(8'h01, 4'd1, 8'd1, 16'd3, 1'b1);
    bit_in(0);
    start = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd0;
    bit_in(0);
    start = 1'b0;
    check("t6 start in run ignored", 32'(cfg_err), 32'd0);
    check("t6 busy", 32'(busy), 32'd1);
    bit_in(1);
    check("t6 pulse", 32'(match_pulse), 32'd1);
    check("t6 count", 32'(match_count), 32'd1);
    start = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_target = 8'd1; cfg_timeout = 16'd0;
    cyc();
    start = 1'b0;
    check("t6 done", 32'(done), 32'd1);
    check("t6 timed_out", 32'(timed_out), 32'd0);
    check("t6 busy in done", 32'(busy), 32'd0);
    cyc();
    check("t6 start in done ignored", 32'(busy), 32'd0);
    check("t6 count held", 32'(match_count), 32'd1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
